axi_mem_arbiter: RTL and testbench

- Shares the single 128-bit AXI4 master port to DRAM between two requesters: instruction-cache refill (read-only) and data-cache refill/writeback (read or write).
- Sits between the cache controllers and the top-level M_AXI_* pins.
- Issues one single-beat transaction at a time and returns data and acknowledgement to the granted requester.

---
 rtl/axi_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_mem_arbiter                                               |
// | Purpose  : Shares one single-beat AXI4 master port to DRAM between the   |
// |            icache refill path (read only) and the dcache refill/         |
// |            writeback path (read or write). One transaction in flight.    |
// | Ports    : clk, rst (async, active-high)                                 |
// |            ic_req/ic_addr -> ic_ack/ic_rdata   (icache requester)        |
// |            dc_req/dc_we/dc_addr/dc_wdata -> dc_ack/dc_rdata (dcache)     |
// |            bus_err : sticky flag, any non-OKAY RRESP/BRESP               |
// |            M_AXI_AR*/R*/AW*/W*/B* : AXI4 master channels (registered)    |
// | Options  : `define ARB_ROUND_ROBIN_EN -> round-robin tie-break;          |
// |            otherwise fixed priority with dcache winning ties.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axi_mem_arbiter #(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ic_req,
   input  logic [ADDR_W-1:0]   ic_addr,
   output logic                ic_ack,
   output logic [DATA_W-1:0]   ic_rdata,
   input  logic                dc_req,
   input  logic                dc_we,
   input  logic [ADDR_W-1:0]   dc_addr,
   input  logic [DATA_W-1:0]   dc_wdata,
   output logic                dc_ack,
   output logic [DATA_W-1:0]   dc_rdata,
   output logic                bus_err,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RLAST,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WLAST,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4
   } state_t;

   // Clears the low 4 address bits so every beat is 16-byte aligned.
   localparam logic [ADDR_W-1:0] C_ALIGN_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                owner_dc_q, owner_dc_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                ic_ack_q, ic_ack_d;
   logic                dc_ack_q, dc_ack_d;
   logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
   logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
   logic                bus_err_q, bus_err_d;

   logic                grant_ok;
   logic                grant_dc;
   logic                aw_done;
   logic                w_done;

   // RLAST carries no information for single-beat reads.
   logic                unused_rlast;
   assign unused_rlast = M_AXI_RLAST;

   // The ack cycle is spent in IDLE but must not grant, so that the acked
   // requester has a cycle to drop its level request.
   assign grant_ok = (state_q == ST_IDLE) && !ic_ack_q && !dc_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_dc_q, last_dc_d;

   assign grant_dc = dc_req && (!ic_req || !last_dc_q);

   always_comb begin
      last_dc_d = last_dc_q;
      if (grant_ok && (ic_req || dc_req)) begin
         last_dc_d = grant_dc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_dc_q <= 1'b0;
      end else begin
         last_dc_q <= last_dc_d;
      end
   end
`else
   assign grant_dc = dc_req;
`endif

   assign aw_done = !awvalid_q || M_AXI_AWREADY;
   assign w_done  = !wvalid_q  || M_AXI_WREADY;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      owner_dc_d = owner_dc_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      bready_d   = bready_q;
      ic_ack_d   = 1'b0;
      dc_ack_d   = 1'b0;
      ic_rdata_d = ic_rdata_q;
      dc_rdata_d = dc_rdata_q;
      bus_err_d  = bus_err_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_ok) begin
               if (grant_dc) begin
                  owner_dc_d = 1'b1;
                  addr_d     = dc_addr & C_ALIGN_MASK;
                  wdata_d    = dc_wdata;
                  if (dc_we) begin
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = ST_AW_W;
                  end else begin
                     arvalid_d = 1'b1;
                     state_d   = ST_AR;
                  end
               end else if (ic_req) begin
                  owner_dc_d = 1'b0;
                  addr_d     = ic_addr & C_ALIGN_MASK;
                  arvalid_d  = 1'b1;
                  state_d    = ST_AR;
               end
            end
         end
         ST_AR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_R;
            end
         end
         ST_R: begin
            if (M_AXI_RVALID) begin
               rready_d = 1'b0;
               if (owner_dc_q) begin
                  dc_rdata_d = M_AXI_RDATA;
                  dc_ack_d   = 1'b1;
               end else begin
                  ic_rdata_d = M_AXI_RDATA;
                  ic_ack_d   = 1'b1;
               end
               if (M_AXI_RRESP != 2'b00) begin
                  bus_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         ST_AW_W: begin
            // Address and data handshakes complete independently.
            if (M_AXI_AWREADY) begin
               awvalid_d = 1'b0;
            end
            if (M_AXI_WREADY) begin
               wvalid_d = 1'b0;
            end
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = ST_B;
            end
         end
         ST_B: begin
            if (M_AXI_BVALID) begin
               bready_d = 1'b0;
               dc_ack_d = 1'b1;
               if (M_AXI_BRESP != 2'b00) begin
                  bus_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         owner_dc_q <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         ic_ack_q   <= 1'b0;
         dc_ack_q   <= 1'b0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         owner_dc_q <= owner_dc_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         bready_q   <= bready_d;
         ic_ack_q   <= ic_ack_d;
         dc_ack_q   <= dc_ack_d;
         ic_rdata_q <= ic_rdata_d;
         dc_rdata_q <= dc_rdata_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign ic_ack        = ic_ack_q;
   assign ic_rdata      = ic_rdata_q;
   assign dc_ack        = dc_ack_q;
   assign dc_rdata      = dc_rdata_q;
   assign bus_err       = bus_err_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WLAST   = wvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_mem_arbiter                                            |
// | Purpose  : Directed self-checking bench for axi_mem_arbiter. The AXI     |
// |            slave side is driven by hand from the stimulus sequence.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_axi_mem_arbiter;
   localparam int ADDR_W = 27;
   localparam int DATA_W = 128;

   logic                clk = 1'b0;
   logic                rst;
   logic                ic_req;
   logic [ADDR_W-1:0]   ic_addr;
   logic                ic_ack;
   logic [DATA_W-1:0]   ic_rdata;
   logic                dc_req;
   logic                dc_we;
   logic [ADDR_W-1:0]   dc_addr;
   logic [DATA_W-1:0]   dc_wdata;
   logic                dc_ack;
   logic [DATA_W-1:0]   dc_rdata;
   logic                bus_err;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata), .bus_err(bus_err),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
   );

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for AR, checks the address, completes AR and R with
   // zero wait states and checks the ack lands on the expected requester.
   task automatic expect_read(input string tag, input logic [ADDR_W-1:0] exp_addr,
                              input bit is_dc, input logic [DATA_W-1:0] data,
                              input logic [1:0] resp);
      int n = 0;
      while (!arvalid && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_arvalid"}, DATA_W'(arvalid), DATA_W'(1'b1));
      check({tag, "_araddr"}, DATA_W'(araddr), DATA_W'(exp_addr));
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check({tag, "_rready"}, DATA_W'(rready), DATA_W'(1'b1));
      rvalid = 1'b1;
      rdata  = data;
      rresp  = resp;
      tick();
      rvalid = 1'b0;
      rresp  = 2'b00;
      check({tag, "_ic_ack"}, DATA_W'(ic_ack), DATA_W'(!is_dc));
      check({tag, "_dc_ack"}, DATA_W'(dc_ack), DATA_W'(is_dc));
      check({tag, "_rdata"}, is_dc ? dc_rdata : ic_rdata, data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ic_req = 1'b0; ic_addr = '0;
      dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
      arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_arvalid", DATA_W'(arvalid), '0);
      check("rst_awvalid", DATA_W'(awvalid), '0);
      check("rst_wvalid",  DATA_W'(wvalid),  '0);
      check("rst_rready",  DATA_W'(rready),  '0);
      check("rst_bready",  DATA_W'(bready),  '0);
      check("rst_acks",    DATA_W'({ic_ack, dc_ack}), '0);
      check("rst_bus_err", DATA_W'(bus_err), '0);
      check("rst_araddr",  DATA_W'(araddr),  '0);
      rst = 1'b0;
      tick();

      // 1: icache read, minimum latency, unaligned address
      ic_req = 1'b1; ic_addr = 27'h0000123;
      tick();
      check("t1_arvalid", DATA_W'(arvalid), DATA_W'(1'b1));
      check("t1_araddr",  DATA_W'(araddr),  DATA_W'(27'h0000120));
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("t1_arvalid_drop", DATA_W'(arvalid), '0);
      check("t1_rready", DATA_W'(rready), DATA_W'(1'b1));
      rvalid = 1'b1; rdata = {16{8'hA5}};
      tick();
      rvalid = 1'b0;
      check("t1_ic_ack", DATA_W'(ic_ack), DATA_W'(1'b1));
      check("t1_ic_rdata", ic_rdata, {16{8'hA5}});
      check("t1_dc_ack", DATA_W'(dc_ack), '0);
      check("t1_rready_drop", DATA_W'(rready), '0);
      ic_req = 1'b0;
      tick();
      check("t1_ack_pulse", DATA_W'(ic_ack), '0);

      // 2: dcache writeback, AWREADY and WREADY in different cycles
      dc_req = 1'b1; dc_we = 1'b1; dc_addr = 27'h0000040; dc_wdata = 128'h1234;
      tick();
      check("t2_awvalid", DATA_W'(awvalid), DATA_W'(1'b1));
      check("t2_wvalid",  DATA_W'(wvalid),  DATA_W'(1'b1));
      check("t2_awaddr",  DATA_W'(awaddr),  DATA_W'(27'h0000040));
      check("t2_wdata",   wdata, 128'h1234);
      check("t2_wstrb",   DATA_W'(wstrb), DATA_W'(16'hFFFF));
      check("t2_wlast",   DATA_W'(wlast), DATA_W'(1'b1));
      check("t2_arvalid", DATA_W'(arvalid), '0);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      check("t2_aw_drop",   DATA_W'(awvalid), '0);
      check("t2_w_hold",    DATA_W'(wvalid),  DATA_W'(1'b1));
      check("t2_no_b_yet",  DATA_W'(bready),  '0);
      tick();
      check("t2_w_hold2",   DATA_W'(wvalid),  DATA_W'(1'b1));
      check("t2_no_b_yet2", DATA_W'(bready),  '0);
      wready = 1'b1;
      tick();
      wready = 1'b0;
      check("t2_w_drop", DATA_W'(wvalid), '0);
      check("t2_bready", DATA_W'(bready), DATA_W'(1'b1));
      check("t2_no_ack_early", DATA_W'(dc_ack), '0);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check("t2_dc_ack", DATA_W'(dc_ack), DATA_W'(1'b1));
      check("t2_ic_ack", DATA_W'(ic_ack), '0);
      check("t2_bready_drop", DATA_W'(bready), '0);
      dc_req = 1'b0; dc_we = 1'b0;
      tick();
      check("t2_ack_pulse", DATA_W'(dc_ack), '0);

      // 3: simultaneous requests from reset, then a tie after a dcache grant
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ic_req = 1'b1; ic_addr = 27'h0000200;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 27'h0000300;
      expect_read("tie1_first", 27'h0000300, 1'b1, {4{32'hDC00_0001}}, 2'b00);
      dc_req = 1'b0;
      expect_read("tie1_second", 27'h0000200, 1'b0, {4{32'h1C00_0001}}, 2'b00);
      ic_req = 1'b0;
      tick();
      dc_req = 1'b1; dc_addr = 27'h0000310;
      expect_read("lone_dc", 27'h0000310, 1'b1, {4{32'hDC00_0002}}, 2'b00);
      dc_req = 1'b0;
      tick();
      ic_req = 1'b1; ic_addr = 27'h0000210;
      dc_req = 1'b1; dc_addr = 27'h0000320;
`ifdef ARB_ROUND_ROBIN_EN
      expect_read("tie2_first", 27'h0000210, 1'b0, {4{32'h1C00_0003}}, 2'b00);
      ic_req = 1'b0;
      expect_read("tie2_second", 27'h0000320, 1'b1, {4{32'hDC00_0003}}, 2'b00);
      dc_req = 1'b0;
`else
      expect_read("tie2_first", 27'h0000320, 1'b1, {4{32'hDC00_0003}}, 2'b00);
      dc_req = 1'b0;
      expect_read("tie2_second", 27'h0000210, 1'b0, {4{32'h1C00_0003}}, 2'b00);
      ic_req = 1'b0;
`endif
      tick();

      // 4: error response sets sticky bus_err, ack still delivered
      check("t4_berr_pre", DATA_W'(bus_err), '0);
      ic_req = 1'b1; ic_addr = 27'h0000455;
      expect_read("err_rd", 27'h0000450, 1'b0, {4{32'hBAD0_0BAD}}, 2'b10);
      ic_req = 1'b0;
      check("t4_berr_set", DATA_W'(bus_err), DATA_W'(1'b1));
      tick();
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 27'h0000500;
      expect_read("ok_rd", 27'h0000500, 1'b1, {4{32'h600D_600D}}, 2'b00);
      dc_req = 1'b0;
      check("t4_berr_sticky", DATA_W'(bus_err), DATA_W'(1'b1));
      tick();

      // 5a: ARREADY withheld for 10 cycles, AR must stay stable
      ic_req = 1'b1; ic_addr = 27'h0ABCDEF;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("t5_hold_arvalid", DATA_W'(arvalid), DATA_W'(1'b1));
         check("t5_hold_araddr",  DATA_W'(araddr),  DATA_W'(27'h0ABCDE0));
         tick();
      end
      expect_read("hold_rd", 27'h0ABCDE0, 1'b0, {4{32'h0DD0_0DD0}}, 2'b00);
      ic_req = 1'b0;
      tick();

      // 5b: reset in the middle of an AR wait
      ic_req = 1'b1; ic_addr = 27'h0000777;
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("t5_pre_rst_arvalid", DATA_W'(arvalid), DATA_W'(1'b1));
      rst = 1'b1;
      #1;
      check("t5_rst_arvalid", DATA_W'(arvalid), '0);
      check("t5_rst_rready",  DATA_W'(rready),  '0);
      check("t5_rst_bus_err", DATA_W'(bus_err), '0);
      ic_req = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_no_ack", DATA_W'({ic_ack, dc_ack, arvalid}), '0);
      end
      ic_req = 1'b1; ic_addr = 27'h0000888;
      tick();
      check("t5_post_rst_grant", DATA_W'(arvalid), DATA_W'(1'b1));
      expect_read("post_rst", 27'h0000880, 1'b0, {4{32'h8888_8888}}, 2'b00);
      ic_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
